// File: rtl/serial_pkg.sv
// Shared types and constants for the serial echo path line buffer.
package serial_pkg;

    // Line buffer controller states.
    typedef enum bit [0:0] {
        Receive  = 1'b0,
        Transmit = 1'b1
    } t_linebuf_state;

    // Default terminator that ends a line (carriage return).
    localparam logic [7:0] LINEBUF_TERM_CHAR = 8'h0d;

endpackage

// File: rtl/line_ram.sv
// Line storage: DEPTH x BITS, one synchronous write port and one registered
// read port. A read of the address being written in the same cycle returns
// the new data, so a word can be presented the cycle after it is stored.
module line_ram #(
    parameter  int BITS      = 8,
    parameter  int DEPTH     = 16,
    localparam int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_we,
    input  logic [ADDR_BITS-1:0] in_waddr,
    input  logic [BITS-1:0]      in_wdata,
    input  logic                 in_re,
    input  logic [ADDR_BITS-1:0] in_raddr,
    output logic [BITS-1:0]      out_rdata
);

    logic [BITS-1:0] mem_q [DEPTH];
    logic [BITS-1:0] rdata_q;

    // Store one word per write strobe.
    // NOTE: the array has no reset; every word is written before it is ever read, and a reset branch would block RAM inference.
    always_ff @(posedge in_clk) begin
        if (in_we) begin
            mem_q[in_waddr] <= in_wdata;
        end
    end

    // Registered read with write-through bypass; holds its value when not reading.
    // NOTE: non-blocking assignments keep every register updating from the pre-edge values, independent of block order.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            rdata_q <= '0;
        end else if (in_re) begin
            if (in_we && (in_waddr == in_raddr)) begin
                rdata_q <= in_wdata;
            end else begin
                rdata_q <= mem_q[in_raddr];
            end
        end
    end

    assign out_rdata = rdata_q;

endmodule

// File: rtl/serial_line_buffer.sv
// Line-granular echo buffer between serial_async_rx and serial_async_tx.
// Collects received words until TERM_CHAR or a full buffer, then replays the
// line one word per transmitter handshake and returns to receiving.
module serial_line_buffer
    import serial_pkg::*;
#(
    parameter  int              BITS      = 8,
    parameter  int              DEPTH     = 16,
    parameter  logic [BITS-1:0] TERM_CHAR = LINEBUF_TERM_CHAR,
    localparam int              CNT_BITS  = $clog2(DEPTH) + 1
) (
    input  logic                in_clk,
    input  logic                in_rst,
    output logic                out_rx_enable,
    input  logic [BITS-1:0]     in_rx_char,
    input  logic                in_rx_word_finished,
    output logic                out_tx_enable,
    output logic [BITS-1:0]     out_tx_char,
    input  logic                in_tx_next_word,
    output logic                out_line_ready,
    output logic [CNT_BITS-1:0] out_count,
    output logic                out_overflow
);

    localparam int PTR_BITS = CNT_BITS - 1;

    t_linebuf_state      state_q, state_d;
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                last_rx_q, last_tx_q;

    logic                rx_evt, tx_evt;
    logic                ram_we, ram_re;
    logic                line_full;
    logic                last_word;

    // Falling edges of the rx/tx handshake levels mark a finished word
    // and a word latched by the transmitter respectively.
    assign rx_evt = ~in_rx_word_finished & last_rx_q;
    assign tx_evt = ~in_tx_next_word & last_tx_q;

    // This write fills the last free slot.
    assign line_full = (count_q == CNT_BITS'(DEPTH - 1));
    // The word currently presented is the final one of the line.
    assign last_word = ({1'b0, rd_ptr_q} == (count_q - CNT_BITS'(1)));

    // Register the handshake levels for edge detection.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            last_rx_q <= 1'b0;
            last_tx_q <= 1'b0;
        end else begin
            last_rx_q <= in_rx_word_finished;
            last_tx_q <= in_tx_next_word;
        end
    end

    // Controller state, pointers, word count and sticky overflow.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q    <= Receive;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state logic: store words in Receive, replay them in Transmit.
    // NOTE: every signal gets a default before the case so no path leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        ram_we     = 1'b0;

        unique case (state_q)
            Receive: begin
                if (rx_evt) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
                    count_d  = count_q + CNT_BITS'(1);
                    if ((in_rx_char == TERM_CHAR) || line_full) begin
                        state_d = Transmit;
                    end
                    if ((in_rx_char != TERM_CHAR) && line_full) begin
                        overflow_d = 1'b1;
                    end
                end
            end
            Transmit: begin
                // The receiver is disabled here; any word it still delivers is lost.
                if (rx_evt) begin
                    overflow_d = 1'b1;
                end
                if (tx_evt) begin
                    if (last_word) begin
                        state_d  = Receive;
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        count_d  = '0;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
                    end
                end
            end
            default: state_d = Receive;
        endcase

        // Fetch the next word whenever the following cycle is a Transmit
        // cycle, so out_tx_char is valid from the first one onward.
        ram_re = (state_d == Transmit);
    end

    line_ram #(
        .BITS  (BITS),
        .DEPTH (DEPTH)
    ) u_line_ram (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .in_we     (ram_we),
        .in_waddr  (wr_ptr_q),
        .in_wdata  (in_rx_char),
        .in_re     (ram_re),
        .in_raddr  (rd_ptr_d),
        .out_rdata (out_tx_char)
    );

    assign out_rx_enable  = (state_q == Receive);
    assign out_tx_enable  = (state_q == Transmit);
    assign out_line_ready = (state_q == Transmit);
    assign out_count      = count_q;
    assign out_overflow   = overflow_q;

endmodule

// File: doc/serial_line_buffer.md
Name: serial_line_buffer

Overview:
- Sits between serial_async_rx and serial_async_tx on the serial echo path.
- Collects received bytes into a line buffer until a terminator byte arrives or the buffer fills.
- Then replays the whole line through the transmitter, one word per transmitter handshake, and returns to receiving.
- Replaces the single-character echo FSM with line-granular buffering.

Parameters:
- BITS, 8, word width in bits; matches the rx/tx modules.
- DEPTH, 16, buffer capacity in words; power of two, at least 2.
- TERM_CHAR, 8'h0d, terminator that ends a line; it is stored and echoed.
- CNT_BITS, $clog2(DEPTH) + 1, width of the count outputs; derived, not overridden.

Ports:
- in_clk, in, 1, main clock.
- in_rst, in, 1, asynchronous active-high reset.
- out_rx_enable, out, 1, enable to serial_async_rx.in_enable.
- in_rx_char, in, BITS, from serial_async_rx.out_parallel.
- in_rx_word_finished, in, 1, from serial_async_rx.out_word_finished (level).
- out_tx_enable, out, 1, to serial_async_tx.in_enable.
- out_tx_char, out, BITS, to serial_async_tx.in_parallel.
- in_tx_next_word, in, 1, from serial_async_tx.out_next_word (level).
- out_line_ready, out, 1, high while in Transmit.
- out_count, out, CNT_BITS, number of words stored in the current line.
- out_overflow, out, 1, sticky flag: a line was cut at DEPTH, or a byte was dropped.

Behaviour:
- Reset (async, any time, including mid-line or mid-transmit):
  - state = Receive; write/read pointers = 0; count = 0.
  - out_overflow = 0; out_tx_char = 0; edge registers = 0.
  - Resulting outputs: out_rx_enable = 1, out_tx_enable = 0, out_line_ready = 0.
- Edge detection:
  - Registered copies of in_rx_word_finished and in_tx_next_word.
  - rx_evt = ~in_rx_word_finished & last_rx; tx_evt = ~in_tx_next_word & last_tx.
  - Each event is a single-cycle falling-edge pulse.
- State Receive:
  - out_rx_enable = 1, out_tx_enable = 0.
  - On rx_evt in cycle N: buf[wr_ptr] <= in_rx_char, wr_ptr++, count++ at the end of N.
  - If the char equals TERM_CHAR, or count reaches DEPTH after this write, next state is Transmit. out_tx_enable and out_line_ready are high from N+1.
  - Reaching DEPTH without a terminator also sets out_overflow.
- State Transmit:
  - out_rx_enable = 0, out_tx_enable = 1.
  - out_tx_char = buf[rd_ptr], registered and valid from the first Transmit cycle.
  - On tx_evt the transmitter has latched the current word: rd_ptr++ and the next word is presented the following cycle.
  - When tx_evt consumes word count-1: next state is Receive; pointers and count clear; out_tx_enable drops the next cycle.
  - The transmitter finishes its in-flight word by itself after enable drops.
- Ignored and dropped events:
  - An rx_evt during Transmit sets out_overflow; the byte is discarded.
  - A tx_evt during Receive is ignored.
- Boundaries:
  - A lone TERM_CHAR is a 1-word line.
  - Exactly DEPTH words ending in TERM_CHAR is a normal line: no overflow.
  - Pointers are CNT_BITS-1 wide and wrap naturally, but never wrap within one line because they clear per line.
  - out_overflow stays set until reset.
- Throughput: 1-cycle latency from the terminator's rx_evt to out_tx_enable; no combinational path from any input to any output.

Decomposition:
- serial_pkg: t_linebuf_state enum {Receive, Transmit} (bit [0:0]) and the default TERM_CHAR constant.
- Sub-module line_ram: DEPTH x BITS, single write port, registered read port; synchronous write, no reset on contents.
- Edge detectors and FSM stay in serial_line_buffer.

Test Plan:
- Reset, then send "ab\r" (8'h61, 8'h62, 8'h0d) via rx_evt pulses -> out_count 3; out_tx_enable rises 1 cycle after the third rx_evt; out_tx_char shows 61, 62, 0d on successive tx_evt; returns to Receive, count 0, overflow 0.
- Lone 8'h0d -> 1-word line; exactly one tx_evt needed before returning to Receive.
- 16 bytes 8'h30..8'h3f with no terminator -> Transmit after the 16th; out_overflow = 1; 16 words echoed in order.
- 15 bytes followed by 8'h0d (16 total) -> echoed fully; out_overflow stays 0.
- rx_evt injected during Transmit of "xy\r" -> byte not stored, out_overflow = 1, echo unchanged.
- Assert in_rst after the 2nd tx_evt of a 3-word line -> out_tx_enable 0 immediately; count 0; out_rx_enable 1; next line "z\r" echoes correctly.
